// File: rtl/systolic_2x2_feeder.sv
// systolic_2x2_feeder
// Sequences one 2x2 tile through a systolic array: takes a tile command,
// optionally clears the array, pulses start, streams operand beats onto the
// array inputs, waits for done (bounded by TIMEOUT) and holds the captured
// result until it is consumed.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// edge where both valid and ready are 1. A source keeps valid and payload
// stable until the transfer. cmd_ready_o and op_ready_o are registered and
// never depend combinationally on the matching valid. res_valid_o stays set
// and res_c*_o/res_err_o stay stable until res_ready_i is seen.
module systolic_2x2_feeder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACCUM_WIDTH = 64,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_accum_i,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [DATA_WIDTH-1:0]  op_a0_i,
    input  logic [DATA_WIDTH-1:0]  op_a1_i,
    input  logic [DATA_WIDTH-1:0]  op_b0_i,
    input  logic [DATA_WIDTH-1:0]  op_b1_i,
    input  logic                   op_last_i,
    output logic                   start_o,
    output logic                   clear_o,
    output logic                   accumulate_o,
    output logic [DATA_WIDTH-1:0]  a_row0_o,
    output logic [DATA_WIDTH-1:0]  a_row1_o,
    output logic [DATA_WIDTH-1:0]  b_col0_o,
    output logic [DATA_WIDTH-1:0]  b_col1_o,
    output logic                   a_valid_o,
    output logic                   b_valid_o,
    input  logic                   busy_i,
    input  logic                   done_i,
    input  logic [ACCUM_WIDTH-1:0] c00_i,
    input  logic [ACCUM_WIDTH-1:0] c01_i,
    input  logic [ACCUM_WIDTH-1:0] c10_i,
    input  logic [ACCUM_WIDTH-1:0] c11_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [ACCUM_WIDTH-1:0] res_c00_o,
    output logic [ACCUM_WIDTH-1:0] res_c01_o,
    output logic [ACCUM_WIDTH-1:0] res_c10_o,
    output logic [ACCUM_WIDTH-1:0] res_c11_o,
    output logic                   res_err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        START  = 3'd2,
        FEED   = 3'd3,
        WAIT   = 3'd4,
        RESULT = 3'd5
    } state_t;

    // Last value of the wait counter before the timeout fires (TIMEOUT cycles in WAIT).
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    // Count value of the 8th beat of a tile.
    localparam logic [3:0] BEAT_LAST = 4'd7;

    state_t     state;
    logic [3:0] beat_cnt;
    logic [7:0] wait_cnt;
    logic       overflow;

    logic cmd_fire;
    logic beat_fire;
    logic res_fire;

    // busy_i carries no information this sequencer needs; done_i alone ends WAIT.
    logic unused_busy;
    assign unused_busy = busy_i;

    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    assign beat_fire = op_valid_i && op_ready_o;
    assign res_fire  = res_valid_o && res_ready_i;

    // Tile sequencer: state, counters and every output are registered here.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            wait_cnt     <= '0;
            overflow     <= 1'b0;
            cmd_ready_o  <= 1'b0;
            op_ready_o   <= 1'b0;
            start_o      <= 1'b0;
            clear_o      <= 1'b0;
            accumulate_o <= 1'b0;
            a_row0_o     <= '0;
            a_row1_o     <= '0;
            b_col0_o     <= '0;
            b_col1_o     <= '0;
            a_valid_o    <= 1'b0;
            b_valid_o    <= 1'b0;
            res_valid_o  <= 1'b0;
            res_c00_o    <= '0;
            res_c01_o    <= '0;
            res_c10_o    <= '0;
            res_c11_o    <= '0;
            res_err_o    <= 1'b0;
        end else begin
            // Single-cycle pulses and operand valids fall unless re-armed below.
            start_o   <= 1'b0;
            clear_o   <= 1'b0;
            a_valid_o <= 1'b0;
            b_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready_o  <= 1'b0;
                        accumulate_o <= cmd_accum_i;
                        if (cmd_accum_i) begin
                            start_o <= 1'b1;
                            state   <= START;
                        end else begin
                            clear_o <= 1'b1;
                            state   <= CLEAR;
                        end
                    end
                end

                CLEAR: begin
                    start_o <= 1'b1;
                    state   <= START;
                end

                START: begin
                    beat_cnt   <= '0;
                    wait_cnt   <= '0;
                    overflow   <= 1'b0;
                    res_err_o  <= 1'b0;
                    op_ready_o <= 1'b1;
                    state      <= FEED;
                end

                FEED: begin
                    if (beat_fire) begin
                        a_row0_o  <= op_a0_i;
                        a_row1_o  <= op_a1_i;
                        b_col0_o  <= op_b0_i;
                        b_col1_o  <= op_b1_i;
                        a_valid_o <= 1'b1;
                        b_valid_o <= 1'b1;
                        beat_cnt  <= beat_cnt + 4'd1;
                        if (op_last_i || (beat_cnt == BEAT_LAST)) begin
                            // Reaching here without op_last_i means the 8th beat overran the tile.
                            overflow   <= !op_last_i;
                            op_ready_o <= 1'b0;
                            state      <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    // done_i is checked first so it wins over a simultaneous timeout.
                    if (done_i || (wait_cnt == WAIT_LAST)) begin
                        res_c00_o   <= c00_i;
                        res_c01_o   <= c01_i;
                        res_c10_o   <= c10_i;
                        res_c11_o   <= c11_i;
                        res_valid_o <= 1'b1;
                        res_err_o   <= overflow || !done_i;
                        state       <= RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESULT: begin
                    if (res_fire) begin
                        res_valid_o  <= 1'b0;
                        accumulate_o <= 1'b0;
                        cmd_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_2x2_feeder.md
SYSTOLIC_2X2_FEEDER -- requirements
Module: systolic_2x2_feeder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, operand width.
- ACCUM_WIDTH, 64, result element width.
- TIMEOUT, 64, cycles to wait for array done before flagging an error (range 2..255).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all logic on rising edge.
- rst_ni, in, 1, reset, synchronous, active-low.
- cmd_valid_i, in, 1, tile request valid.
- cmd_ready_o, out, 1, tile request accepted.
- cmd_accum_i, in, 1, 1 = add onto existing accumulators; 0 = clear first.
- op_valid_i, in, 1, operand beat valid.
- op_ready_o, out, 1, operand beat accepted.
- op_a0_i / op_a1_i, in, DATA_WIDTH each, A row0 / row1 element.
- op_b0_i / op_b1_i, in, DATA_WIDTH each, B col0 / col1 element.
- op_last_i, in, 1, final beat of the tile.
- start_o, clear_o, accumulate_o, out, 1 each, array control.
- a_row0_o, a_row1_o, b_col0_o, b_col1_o, out, DATA_WIDTH each, array operands.
- a_valid_o, b_valid_o, out, 1 each, array operand valids.
- busy_i, done_i, in, 1 each, array status.
- c00_i, c01_i, c10_i, c11_i, in, ACCUM_WIDTH each, array results.
- res_valid_o, out, 1, result valid.
- res_ready_i, in, 1, result consumed.
- res_c00_o .. res_c11_o, out, ACCUM_WIDTH each, captured results.
- res_err_o, out, 1, result produced by timeout or beat overflow.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, START, FEED, WAIT, RESULT.
REQ-004 IDLE: cmd_ready_o=1 only here. A handshake latches cmd_accum_i into accumulate_o and transitions to CLEAR if the latched value is 0, otherwise to START.
REQ-005 CLEAR: clear_o=1 for exactly one cycle, then START.
REQ-006 START: start_o=1 for exactly one cycle, then FEED. Beat counter and timeout counter SHALL be zeroed here.
REQ-007 FEED: op_ready_o=1. Each accepted beat SHALL be registered onto the a_*/b_* outputs with a_valid_o=b_valid_o=1 in the following cycle.
REQ-008 In a FEED cycle with no accepted beat, a_valid_o=b_valid_o=0 on the next cycle and the operand outputs SHALL hold their previous values.
REQ-009 The beat counter SHALL be 4 bits. An accepted beat with op_last_i=1, or the 8th accepted beat, SHALL cause a transition to WAIT. The 8th beat with op_last_i=0 SHALL set the overflow flag.
REQ-010 WAIT: op_ready_o=0, and the last registered beat SHALL remain valid for one cycle only.
REQ-011 In WAIT, done_i=1 SHALL capture c00_i..c11_i into res_c*_o and transition to RESULT with res_valid_o=1 next cycle.
REQ-012 In WAIT, if TIMEOUT cycles elapse without done_i, the FSM SHALL capture the current c*_i values, set res_err_o=1, and go to RESULT.
REQ-013 res_err_o SHALL also be 1 if the overflow flag is set, and SHALL be cleared in START.
REQ-014 RESULT: res_valid_o and res_c*_o SHALL be held stable until res_ready_i=1, then the FSM returns to IDLE. cmd_ready_o SHALL be reasserted the cycle after that handshake, so there is no same-cycle back-to-back.
REQ-015 done_i and busy_i SHALL be ignored outside WAIT. done_i arriving in the same cycle as the timeout expiry SHALL win, giving res_err_o=0 unless overflow is set.
REQ-016 accumulate_o SHALL be held from the command handshake until return to IDLE.
REQ-017 start_o and clear_o SHALL never be asserted in the same cycle, and each SHALL be asserted at most once per command.

Reset
REQ-018 With rst_ni=0 sampled at a clock edge, the FSM SHALL go to IDLE.
REQ-019 During reset, all outputs SHALL be 0 except cmd_ready_o, which is 1 from the first cycle after reset release.
REQ-020 Counters and result registers SHALL be zeroed by reset, and reset mid-operation SHALL abandon the tile with no result produced.

Verification
REQ-021 Non-accumulating tile: A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats (1,3,5,6) then (2,4,7,8, last), array model returns done with 19,22,43,50 -> clear_o, then start_o the next cycle, two valid beats, res_c00..c11 = 19,22,43,50, res_err_o=0.
REQ-022 cmd_accum_i=1 -> no clear_o pulse, accumulate_o=1 throughout, start_o in the cycle after the handshake.
REQ-023 op_valid_i bubble between beats -> a_valid_o=0 for exactly one cycle, operand outputs unchanged.
REQ-024 done_i never asserted -> RESULT entered TIMEOUT cycles after WAIT entry, res_err_o=1.
REQ-025 Nine beats with no op_last_i -> 8 beats accepted, op_ready_o=0 from beat 9, res_err_o=1.
REQ-026 rst_ni=0 during FEED -> the next cycle shows IDLE, all outputs 0, and no res_valid_o for the aborted tile.
